// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input plus a registered sign output.
module bin2bcd_seq #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  sign
`endif
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SCR_W = BCD_W + IN_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [SCR_W-1:0]   scr;
  logic [SCR_W-1:0]   scr_adj_c;
  logic [SCR_W-1:0]   scr_next_c;
  logic               top_out_c;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_scr;
  logic [IN_W-1:0]    operand_c;
`ifdef BIN2BCD_SIGNED_EN
  logic               sign_scr;
`endif

  // Operand as loaded into the shift register: magnitude when signed input is enabled.
`ifdef BIN2BCD_SIGNED_EN
  always_comb begin
    operand_c = bin_in;
    if (bin_in[IN_W-1]) begin
      operand_c = IN_W'(~bin_in + IN_W'(1));
    end
  end
`else
  always_comb begin
    operand_c = bin_in;
  end
`endif

  // One double-dabble iteration: add 3 to every scratch digit >= 5, then shift left.
  always_comb begin
    scr_adj_c = scr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scr[IN_W + 4*d +: 4] >= 4'd5) begin
        scr_adj_c[IN_W + 4*d +: 4] = scr[IN_W + 4*d +: 4] + 4'd3;
      end
    end
    top_out_c  = scr_adj_c[SCR_W-1];
    scr_next_c = {scr_adj_c[SCR_W-2:0], 1'b0};
  end

  // Control FSM with registered handshake and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      scr      <= '0;
      cnt      <= '0;
      ovf_scr  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign     <= 1'b0;
      sign_scr <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            scr     <= {{BCD_W{1'b0}}, operand_c};
            cnt     <= CNT_W'(IN_W);
            ovf_scr <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_scr <= bin_in[IN_W-1];
`endif
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          scr     <= scr_next_c;
          cnt     <= cnt - CNT_W'(1);
          ovf_scr <= ovf_scr | top_out_c;
          // Last iteration: publish the result straight from the shifted scratch.
          if (cnt == CNT_W'(1)) begin
            bcd_out  <= scr_next_c[SCR_W-1 -: BCD_W];
            overflow <= ovf_scr | top_out_c;
`ifdef BIN2BCD_SIGNED_EN
            sign     <= sign_scr;
`endif
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Replaces the fixed 8-bit combinational converter wherever area matters more than latency.
- Adds a start/busy/done handshake, a registered result and overflow detection.
- Sits between binary datapath counters and display/BCD consumers.

Parameters:
- IN_W, 8, binary input width in bits (legal range 2..32).
- DIGITS, 3, number of BCD output digits (each 4 bits).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > IN_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE or DONE.
- bin_in  input  IN_W  unsigned binary operand; captured on the edge that accepts start.
- busy  output  1  high while iterating (SHIFT state).
- done  output  1  one-cycle pulse; bcd_out/overflow valid from this cycle on.
- bcd_out  output  4*DIGITS  registered result; digit 0 (ones) in bits [3:0].
- overflow  output  1  registered; high if the value does not fit in DIGITS digits.

Behaviour:
- Reset (async, any time including mid-conversion): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, shift register and counter cleared. First conversion after reset release needs a fresh start.
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 → load shift register {BCD scratch=0, bin=bin_in}, counter=IN_W, overflow scratch=0, go to SHIFT.
  - SHIFT: each edge performs one iteration:
    - every scratch digit >=5 gets +3 (4-bit add, no carry between digits);
    - then the whole register shifts left by 1;
    - if the bit shifted out of the top digit is 1, set the overflow scratch (sticky);
    - counter decrements.
  - Leaving SHIFT: on the edge where the counter reaches 0, load bcd_out and overflow from scratch, go to DONE.
  - DONE: done=1 for exactly this cycle, then:
    - start=1 → accept a new operand exactly as from IDLE and go to SHIFT (back-to-back conversions);
    - otherwise go to IDLE.
- Timing:
  - busy=1 in all SHIFT cycles, 0 in IDLE/DONE.
  - With start accepted at edge E0, done is high in the cycle after edge E(IN_W); latency is IN_W+1 cycles from start to done.
  - Peak throughput is one result per IN_W+1 cycles.
- start while busy: ignored, with no effect on the in-flight conversion; bin_in changes during SHIFT have no effect.
- bcd_out and overflow hold their last value until the next DONE load; they are never updated mid-conversion.
- Overflow case: bcd_out holds the low DIGITS digits of the true result (value modulo 10^DIGITS).
- Scratch width is 4*DIGITS + IN_W; no internal truncation before the overflow check.

Optional Feature:
- Macro BIN2BCD_SIGNED_EN.
- Defined:
  - bin_in is treated as two's complement.
  - The magnitude is taken at capture (a single unsigned IN_W-bit negate when the MSB is 1; -2^(IN_W-1) therefore converts correctly).
  - An extra output port sign (1 bit, registered, reset 0, updated with bcd_out at DONE) is 1 for negative inputs.
  - Iteration count and latency are unchanged.
- Not defined: the sign port does not exist and bin_in is always unsigned.

Test Plan:
- Reset, then start with bin_in=0 → done pulses 9 cycles after start; bcd_out=12'h000, overflow=0; busy high for exactly 8 cycles.
- bin_in=8'd255 → bcd_out=12'h255, overflow=0. Sweep all values 0..255 and compare each result against a reference model.
- Back-to-back: start held high through DONE with 8'd99 then 8'd100 → done pulses 9 cycles apart; results 12'h099 then 12'h100.
- Pulse start with bin_in=8'd7 at cycle 2 of a conversion of 8'd200 → request ignored; result 12'h200; only one done pulse.
- Reset asserted during the 4th SHIFT cycle → busy/done/bcd_out drop to 0 immediately (asynchronously); no done until a new start.
- DIGITS=2, bin_in=8'd123 → bcd_out=8'h23, overflow=1. With BIN2BCD_SIGNED_EN: bin_in=8'h80 → sign=1, bcd_out=12'h128.
